// File: rtl/dma_copy_engine_pkg.sv
// dma_copy_engine shared types and constants.
// Memory map limits and the FSM state encoding.
package dma_pkg;

  localparam int DATA_W          = 32;
  localparam int ADDR_W          = 8;
  localparam int MEM_DEPTH       = 192;
  localparam int LAST_USABLE     = 190;
  localparam int FIRSTEMPTY_ADDR = 191;
  localparam int CS_BIT          = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD_REQ,
    S_RD_CAP,
    S_WR,
    S_DONE,
    S_ERR
  } dma_state_t;

endpackage

// File: rtl/dma_copy_engine_if.sv
// Request/status bundle between a copy requester and the engine.
// The memory-side bus stays on plain ports.
interface dma_copy_engine_if;
  import dma_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] words_done;

  modport master (
    output start, src_addr, dst_addr, len,
    input  busy, done, error, words_done
  );

  modport slave (
    input  start, src_addr, dst_addr, len,
    output busy, done, error, words_done
  );

endinterface

// File: rtl/dma_copy_engine_range_check.sv
// Combinational request validator: bounds and forward overlap.
// Sums are one bit wider than addresses so nothing wraps.
module dma_range_check
  import dma_pkg::*;
(
  input  logic [ADDR_W-1:0] src_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic              reject_o
);

  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(LAST_USABLE);

  logic [ADDR_W:0] src_lim;
  logic [ADDR_W:0] src_end;
  logic [ADDR_W:0] dst_end;
  logic            nz;
  logic            oob;
  logic            ovl;

  assign nz      = |len_i;
  assign src_lim = {1'b0, src_i} + {1'b0, len_i};
  assign src_end = src_lim - 1'b1;
  assign dst_end = {1'b0, dst_i} + {1'b0, len_i} - 1'b1;

  assign oob = nz && ((src_end > LIM) || (dst_end > LIM));
  // Ascending copy into a later, overlapping window eats its own source.
  assign ovl = (dst_i > src_i) && ({1'b0, dst_i} < src_lim);

  assign reject_o = oob || ovl;

endmodule

// File: rtl/dma_copy_engine.sv
// Single-channel block copy master for the shared word memory.
// Three cycles per word: read request, read capture, write.
module dma_copy_engine
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  dma_copy_engine_if.slave  ctrl,
  output logic [ADDR_W:0]   index,
  output logic              memWR,
  inout  wire  [DATA_W-1:0] databus
);

  dma_state_t state_q, state_d;

  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] wdone_q, wdone_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            we_q, we_d;
  logic [ADDR_W:0] idx_q, idx_d;

  logic reject;
  logic rd_sel;
  logic wr_sel;

  dma_range_check u_rc (
    .src_i    (rd_q),
    .dst_i    (wr_q),
    .len_i    (len_q),
    .reject_o (reject)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      len_q   <= '0;
      wdone_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      len_q   <= len_d;
      wdone_q <= wdone_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (ctrl.start) state_d = S_CHECK;
      S_CHECK: begin
        if (reject)          state_d = S_ERR;
        else if (len_q == '0) state_d = S_DONE;
        else                 state_d = S_RD_REQ;
      end
      S_RD_REQ: state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_WR;
      S_WR: begin
        if (wdone_q + 1'b1 == len_q) state_d = S_DONE;
        else                         state_d = S_RD_REQ;
      end
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they land registered.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    len_d   = len_q;
    wdone_d = wdone_q;
    data_d  = data_q;
    if (state_q == S_IDLE && ctrl.start) begin
      rd_d    = ctrl.src_addr;
      wr_d    = ctrl.dst_addr;
      len_d   = ctrl.len;
      wdone_d = '0;
    end
    if (state_q == S_RD_CAP) data_d = databus;
    if (state_q == S_WR) begin
      rd_d    = rd_q + 1'b1;
      wr_d    = wr_q + 1'b1;
      wdone_d = wdone_q + 1'b1;
    end
    if (state_d == S_ERR) wdone_d = '0;

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
    we_d   = (state_d == S_WR);
    rd_sel = (state_d == S_RD_REQ) || (state_d == S_RD_CAP);
    wr_sel = (state_d == S_WR);
    idx_d  = '0;
    unique case (1'b1)
      rd_sel:  idx_d = {1'b1, rd_d};
      wr_sel:  idx_d = {1'b1, wr_d};
      default: idx_d = '0;
    endcase
  end

  assign ctrl.busy       = busy_q;
  assign ctrl.done       = done_q;
  assign ctrl.error      = err_q;
  assign ctrl.words_done = wdone_q;

  assign index   = idx_q;
  assign memWR   = we_q;
  assign databus = we_q ? data_q : 'z;

endmodule

// File: doc/dma_copy_engine.md
# dma_copy_engine

Block-copy master for the 192-word shared memory: on `start` it reads `len` consecutive 32-bit words from `src_addr` and writes them to `dst_addr`, one word at a time, over the memory's chip-select/address/`memWR`/tri-state `databus` port. It sits directly upstream of the memory. It is the only bus master on that port and owns `index`, `memWR` and the write direction of `databus`.

## Interface
- `DATA_W`, 32: data word width.
- `ADDR_W`, 8: word address width; `index` is `ADDR_W+1` bits wide.
- `MEM_DEPTH`, 192: memory words.
- `LAST_USABLE`, 190: highest copyable address. Word 191 is the memory's reserved first-empty register and is never read or written.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, synchronous and active-low.
- `start`  in  1: request a copy; sampled only in IDLE.
- `src_addr`  in  8: first source word.
- `dst_addr`  in  8: first destination word.
- `len`  in  8: words to copy, 0..191.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse on successful completion, including `len`=0.
- `error`  out  1: one-cycle pulse when the request is rejected.
- `words_done`  out  8: count of words written in the current or last transfer.
- `index`  out  9: bit 8 is the chip select; bits 7:0 are the address.
- `memWR`  out  1: 1 = write, 0 = read.
- `databus`  inout  32: driven with the write data only while `memWR`=1, otherwise high-Z.

## Operation
- States: IDLE, CHECK, RD_REQ, RD_CAP, WR, DONE, ERR.
- IDLE: `index`=0 (CS low), `memWR`=0, bus released. `start`=1 latches `src_addr`, `dst_addr` and `len`, clears `words_done`, and moves to CHECK.
- CHECK: the state has no bus activity. It chooses the next state as follows.
  - ERR if `len`≠0 and `src+len-1` > 190.
  - ERR if `len`≠0 and `dst+len-1` > 190.
  - ERR if `dst` > `src` and `dst` < `src+len`. This is the forward-overlap case, which an ascending copy would corrupt.
  - DONE if `len`=0.
  - RD_REQ otherwise.
  - The range sums are computed 9 bits wide, with no wrap.
- RD_REQ: drive `index`={1,rd_ptr} with `memWR`=0. Go to RD_CAP.
- RD_CAP: hold the same `index`/`memWR`, capture `databus` into the data register at the end of the cycle, then go to WR.
- WR: drive `index`={1,wr_ptr} with `memWR`=1 and `databus`=data register.
  - At the end of the cycle: `rd_ptr`++, `wr_ptr`++, `words_done`++.
  - If `words_done+1`=`len`, go to DONE; otherwise go to RD_REQ.
- DONE: `done`=1, CS low. Go to IDLE.
- ERR: `error`=1, CS low, `words_done`=0. Go to IDLE.
- `start` outside IDLE is ignored; there is no queueing.
- All outputs are registered. `memWR` and the `databus` enable change on the same edge, so the block never drives the bus while the memory drives it.
- Reset (`rst_n`=0 at a rising edge), from any state including mid-word:
  - state=IDLE, `busy`=0, `done`=0, `error`=0, `words_done`=0, `index`=0, `memWR`=0, `databus` high-Z.
  - A partially completed copy is abandoned. Words already written stay written.

## Timing
- Let E0 be the edge that samples `start`. After E1 the state leaves CHECK.
- Each word takes exactly 3 cycles (RD_REQ, RD_CAP, WR). Word i's WR cycle follows edge E(3+3i).
- `done` is high for the one cycle after edge E(3N+1), where N=`len`. `busy` falls after E(3N+2).
- `len`=0: `done` is high in the cycle after E1, with zero bus cycles.
- Rejected request: `error` is high in the cycle after E1; CS stays low throughout.
- `busy` rises in the cycle after E0.
- Back-to-back: `start` held high re-triggers on the first IDLE cycle, 2 cycles after `done`.

## Structure
- Package `dma_pkg` holds:
  - the `dma_state_t` enum;
  - `MEM_DEPTH`, `LAST_USABLE`=190 and `FIRSTEMPTY_ADDR`=191;
  - the `CS_BIT`=8 constant.
- Sub-module `dma_range_check` is purely combinational. It takes `src`, `dst` and `len` and returns `reject`. It is reused by later channel variants.
- The FSM, pointers, data register and tri-state driver live in the top-level module.

## Test plan
- **Basic copy:** `src`=0, `dst`=120, `len`=4 against the memory preloaded with k+1 at address k. Required: words 120..123 = 1,2,3,4; `done` after E13; `words_done`=4; exactly 4 `memWR` pulses.
- **Zero length:** `len`=0. Required: `done` after E1; CS never asserted; `words_done`=0.
- **Range error:** `src`=10, `dst`=188, `len`=4. Required: `error` after E1; `done` never asserted; no write cycles; memory unchanged.
- **Overlap:** `src`=5, `dst`=7, `len`=4 gives `error`. `src`=7, `dst`=5, `len`=4 is accepted and words 5..8 = 8,9,10,11.
- **Reset mid-transfer:** `len`=10, with `rst_n` low during word 3's WR cycle. Required:
  - next cycle all outputs are at their reset values and `databus` is high-Z;
  - destination words 0..2 are written and words 4..9 are untouched;
  - a new `start` then succeeds.
- **Busy-start and max length:** pulse `start` while busy and confirm it is ignored. Then run `src`=0, `dst`=100, `len`=91. Required: `done` after E274 and word 190 written.
